// File: rtl/trig_lut_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : trig_lut_arbiter
// Function : Round-robin front end for one pipelined trig LUT shared by N
//            requesters; a tag pipeline routes each result back to its owner.
// Revision : 1.0  initial release
// ============================================================================
module trig_lut_arbiter #(
    parameter int N       = 4,
    parameter int LUT_LAT = 3,
    parameter int IDW     = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req_valid,
    input  logic [12*N-1:0]   req_degree,
    input  logic [N-1:0]      req_iscos,
    output logic [N-1:0]      req_ready,
    output logic [11:0]       lut_degree,
    output logic              lut_iscos,
    input  logic [9:0]        lut_value,
    output logic [N-1:0]      resp_valid,
    output logic [9:0]        resp_value,
    output logic [IDW-1:0]    resp_id,
    output logic              busy
);

    localparam int c_STAGES = LUT_LAT + 1;
    localparam int c_LAST   = LUT_LAT;

    logic [IDW-1:0]      r_ptr_q;
    logic [IDW-1:0]      w_ptr_d;
    logic [N-1:0]        w_grant;
    logic [IDW-1:0]      w_win_id;
    logic                w_xfer;

    logic [11:0]         r_lut_degree_q;
    logic [11:0]         w_lut_degree_d;
    logic                r_lut_iscos_q;
    logic                w_lut_iscos_d;

    logic [c_STAGES-1:0] r_tag_vld_q;
    logic [c_STAGES-1:0] w_tag_vld_d;
    logic [IDW-1:0]      r_tag_id_q [c_STAGES];
    logic [IDW-1:0]      w_tag_id_d [c_STAGES];

    logic [N-1:0]        r_resp_valid_q;
    logic [N-1:0]        w_resp_valid_d;
    logic [9:0]          r_resp_value_q;
    logic [9:0]          w_resp_value_d;
    logic [IDW-1:0]      r_resp_id_q;
    logic [IDW-1:0]      w_resp_id_d;

    // Two passes: first the requesters at or above the pointer, then wrap to
    // the low indices. Together they form the ascending, wrapping search.
    always_comb begin
        w_grant        = '0;
        w_win_id       = '0;
        w_xfer         = 1'b0;
        w_lut_degree_d = r_lut_degree_q;
        w_lut_iscos_d  = r_lut_iscos_q;
        for (int j = 0; j < N; j++) begin
            if (!w_xfer && req_valid[j] && (IDW'(j) >= r_ptr_q)) begin
                w_xfer     = 1'b1;
                w_grant[j] = 1'b1;
                w_win_id   = IDW'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!w_xfer && req_valid[j]) begin
                w_xfer     = 1'b1;
                w_grant[j] = 1'b1;
                w_win_id   = IDW'(j);
            end
        end
        for (int j = 0; j < N; j++) begin
            if (w_grant[j]) begin
                w_lut_degree_d = req_degree[12*j +: 12];
                w_lut_iscos_d  = req_iscos[j];
            end
        end
    end

    always_comb begin
        w_ptr_d = r_ptr_q;
        if (w_xfer) begin
            w_ptr_d = (w_win_id == IDW'(N - 1)) ? '0 : w_win_id + IDW'(1);
        end
    end

    // Tag pipeline is one stage longer than the LUT so the final stage lines
    // up with the edge that captures lut_value into resp_value.
    always_comb begin
        w_tag_vld_d[0] = w_xfer;
        w_tag_id_d[0]  = w_win_id;
        for (int s = 1; s < c_STAGES; s++) begin
            w_tag_vld_d[s] = r_tag_vld_q[s-1];
            w_tag_id_d[s]  = r_tag_id_q[s-1];
        end
    end

    always_comb begin
        w_resp_valid_d = '0;
        w_resp_value_d = r_resp_value_q;
        w_resp_id_d    = r_resp_id_q;
        if (r_tag_vld_q[c_LAST]) begin
            w_resp_valid_d[r_tag_id_q[c_LAST]] = 1'b1;
            w_resp_value_d                     = lut_value;
            w_resp_id_d                        = r_tag_id_q[c_LAST];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr_q        <= '0;
            r_lut_degree_q <= '0;
            r_lut_iscos_q  <= 1'b0;
            r_tag_vld_q    <= '0;
            for (int s = 0; s < c_STAGES; s++) begin
                r_tag_id_q[s] <= '0;
            end
            r_resp_valid_q <= '0;
            r_resp_value_q <= '0;
            r_resp_id_q    <= '0;
        end else begin
            r_ptr_q        <= w_ptr_d;
            r_lut_degree_q <= w_lut_degree_d;
            r_lut_iscos_q  <= w_lut_iscos_d;
            r_tag_vld_q    <= w_tag_vld_d;
            for (int s = 0; s < c_STAGES; s++) begin
                r_tag_id_q[s] <= w_tag_id_d[s];
            end
            r_resp_valid_q <= w_resp_valid_d;
            r_resp_value_q <= w_resp_value_d;
            r_resp_id_q    <= w_resp_id_d;
        end
    end

    // Grant is masked while reset is held so nothing looks accepted then.
    assign req_ready  = rst ? '0 : w_grant;
    assign lut_degree = r_lut_degree_q;
    assign lut_iscos  = r_lut_iscos_q;
    assign resp_valid = r_resp_valid_q;
    assign resp_value = r_resp_value_q;
    assign resp_id    = r_resp_id_q;
    assign busy       = |r_tag_vld_q;

endmodule
`default_nettype wire

// File: tb/tb_trig_lut_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_trig_lut_arbiter
// Function : Directed bench for trig_lut_arbiter with a behavioural LUT and
//            a per-cycle scoreboard model of arbitration and responses.
// Revision : 1.0  initial release
// ============================================================================
module tb_trig_lut_arbiter;

    localparam int N       = 4;
    localparam int LUT_LAT = 3;
    localparam int IDW     = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      req_valid;
    logic [12*N-1:0]   req_degree;
    logic [N-1:0]      req_iscos;
    logic [N-1:0]      req_ready;
    logic [11:0]       lut_degree;
    logic              lut_iscos;
    logic [9:0]        lut_value;
    logic [N-1:0]      resp_valid;
    logic [9:0]        resp_value;
    logic [IDW-1:0]    resp_id;
    logic              busy;

    always #5 clk = ~clk;

    trig_lut_arbiter #(.N(N), .LUT_LAT(LUT_LAT), .IDW(IDW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_degree (req_degree),
        .req_iscos  (req_iscos),
        .req_ready  (req_ready),
        .lut_degree (lut_degree),
        .lut_iscos  (lut_iscos),
        .lut_value  (lut_value),
        .resp_valid (resp_valid),
        .resp_value (resp_value),
        .resp_id    (resp_id),
        .busy       (busy)
    );

    // Stand-in LUT: any deterministic function of (phase, iscos) suffices.
    function automatic logic [9:0] f(input logic [11:0] p, input logic c);
        logic [31:0] t;
        t = (32'(p) * 32'd7) ^ (32'(p) >> 2) ^ (c ? 32'h2A5 : 32'h0);
        return t[9:0];
    endfunction

    logic [9:0] lut_pipe [LUT_LAT] = '{default: '0};
    always @(posedge clk) begin
        lut_pipe[0] <= f(lut_degree, lut_iscos);
        for (int k = 1; k < LUT_LAT; k++) lut_pipe[k] <= lut_pipe[k-1];
    end
    assign lut_value = lut_pipe[LUT_LAT-1];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- scoreboard model ----------------
    typedef struct {
        int         due;
        int         id;
        logic [9:0] val;
    } exp_t;

    exp_t       sb [$];
    exp_t       e;
    int         m_ptr      = 0;
    logic [11:0] m_deg     = '0;
    logic       m_cos      = 1'b0;
    logic [9:0] m_last_val = '0;
    int         m_last_id  = 0;
    int         m_w;
    logic [N-1:0] m_ready;
    logic [N-1:0] m_rv;
    int         rcnt [N] = '{default: 0};

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_ready", 32'(req_ready), 0);
            chk("rst_lut_degree", 32'(lut_degree), 0);
            chk("rst_lut_iscos", 32'(lut_iscos), 0);
            chk("rst_resp_valid", 32'(resp_valid), 0);
            chk("rst_resp_value", 32'(resp_value), 0);
            chk("rst_resp_id", 32'(resp_id), 0);
            chk("rst_busy", 32'(busy), 0);
            sb.delete();
            m_ptr = 0; m_deg = '0; m_cos = 1'b0; m_last_val = '0; m_last_id = 0;
        end else begin
            m_rv = '0;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                m_rv[e.id] = 1'b1;
                m_last_val = e.val;
                m_last_id  = e.id;
            end
            for (int i = 0; i < N; i++) if (resp_valid[i]) rcnt[i]++;
            chk("resp_valid", 32'(resp_valid), 32'(m_rv));
            chk("resp_value", 32'(resp_value), 32'(m_last_val));
            chk("resp_id", 32'(resp_id), 32'(m_last_id));
            chk("busy", 32'(busy), 32'(sb.size() != 0));
            chk("lut_degree", 32'(lut_degree), 32'(m_deg));
            chk("lut_iscos", 32'(lut_iscos), 32'(m_cos));
            m_w = -1;
            for (int k = 0; k < N; k++)
                if (m_w < 0 && req_valid[(m_ptr + k) % N]) m_w = (m_ptr + k) % N;
            m_ready = '0;
            if (m_w >= 0) m_ready[m_w] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(m_ready));
            if (m_w >= 0) begin
                m_deg = req_degree[12*m_w +: 12];
                m_cos = req_iscos[m_w];
                sb.push_back('{due: cyc + LUT_LAT + 2, id: m_w, val: f(m_deg, m_cos)});
                m_ptr = (m_w + 1) % N;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setreq(input int i, input logic v, input logic [11:0] d, input logic c);
        req_valid[i]           = v;
        req_degree[12*i +: 12] = d;
        req_iscos[i]           = c;
    endtask

    int         base [N];
    int         hits;
    int         first_k;
    logic [9:0] hv [2];

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        req_valid = '0; req_degree = '0; req_iscos = '0;
        repeat (2) tick();
        req_valid = '1;
        @(negedge clk);
        chk("t0_ready_in_reset", 32'(req_ready), 0);
        tick();
        rst = 1'b0; req_valid = '0;
        repeat (2) tick();

        // Test 2: all four valid for 12 cycles
        for (int i = 0; i < N; i++) base[i] = rcnt[i];
        for (int c = 0; c < 12; c++) begin
            for (int i = 0; i < N; i++) setreq(i, 1'b1, 12'(c * 97 + i * 401), 1'((c + i) % 2));
            @(negedge clk);
            chk("t2_grant_order", 32'(req_ready), 32'(1) << (c % 4));
            tick();
        end
        req_valid = '0;
        repeat (6) tick();
        for (int i = 0; i < N; i++) chk("t2_resp_count", 32'(rcnt[i] - base[i]), 3);

        // Test 1: requester 2 alone, back-to-back
        setreq(2, 1'b1, 12'd0, 1'b0);
        @(negedge clk);
        chk("t1_ready_a", 32'(req_ready), 32'b0100);
        tick();
        setreq(2, 1'b1, 12'd1024, 1'b1);
        @(negedge clk);
        chk("t1_ready_b", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        hits = 0; first_k = -1; hv[0] = '1; hv[1] = '1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (resp_valid[2]) begin
                if (hits == 0) first_k = k;
                if (hits < 2) hv[hits] = resp_value;
                hits++;
                chk("t1_resp_id", 32'(resp_id), 2);
            end
        end
        chk("t1_resp_hits", 32'(hits), 2);
        chk("t1_latency", 32'(first_k), 4);
        chk("t1_val_sin0", 32'(hv[0]), 32'h000);
        chk("t1_val_cos1024", 32'(hv[1]), 32'h3A5);
        tick();

        // Test 3: move pointer to 2, then 1 and 3 compete
        setreq(1, 1'b1, 12'd55, 1'b0);
        tick();
        setreq(3, 1'b1, 12'd66, 1'b1);
        @(negedge clk);
        chk("t3_first_3", 32'(req_ready), 32'b1000);
        tick();
        @(negedge clk);
        chk("t3_then_1", 32'(req_ready), 32'b0010);
        tick();
        req_valid = '0;
        repeat (6) tick();

        // Test 4: boundary phases 4095 then 0 from requester 0
        setreq(0, 1'b1, 12'd4095, 1'b0);
        tick();
        setreq(0, 1'b1, 12'd0, 1'b0);
        @(negedge clk);
        chk("t4_deg_4095", 32'(lut_degree), 32'd4095);
        tick();
        req_valid = '0;
        @(negedge clk);
        chk("t4_deg_0", 32'(lut_degree), 32'd0);
        hits = 0; first_k = -1; hv[0] = '1; hv[1] = '1;
        for (int k = 2; k <= 10; k++) begin
            @(negedge clk);
            if (resp_valid[0]) begin
                if (hits == 0) first_k = k;
                if (hits < 2) hv[hits] = resp_value;
                hits++;
            end
        end
        chk("t4_resp_hits", 32'(hits), 2);
        chk("t4_latency", 32'(first_k), 4);
        chk("t4_val_4095", 32'(hv[0]), 32'h006);
        chk("t4_val_0", 32'(hv[1]), 32'h000);
        tick();

        // Test 6: single lookup then idle; busy drops after 4 clocks
        setreq(3, 1'b1, 12'd2047, 1'b1);
        tick();
        req_valid = '0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk("t6_ready_idle", 32'(req_ready), 0);
            chk("t6_deg_hold", 32'(lut_degree), 32'd2047);
            chk("t6_busy", 32'(busy), 32'(k <= 4));
        end
        tick();

        // Test 5: reset with three lookups in flight
        setreq(1, 1'b1, 12'd300, 1'b0); tick();
        setreq(1, 1'b1, 12'd301, 1'b1); tick();
        setreq(1, 1'b1, 12'd302, 1'b0); tick();
        req_valid = '1;
        rst = 1'b1;
        @(negedge clk);
        chk("t5_rst_ready", 32'(req_ready), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_resp_valid", 32'(resp_valid), 0);
        tick(); tick();
        rst = 1'b0; req_valid = '0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            chk("t5_no_stale_resp", 32'(resp_valid), 0);
            chk("t5_busy_idle", 32'(busy), 0);
        end
        tick();
        req_valid = '1;
        @(negedge clk);
        chk("t5_grant_0_first", 32'(req_ready), 32'b0001);
        tick();
        req_valid = '0;
        repeat (8) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
